mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder_if.sv | 25 ++
 rtl/mem_io_responder.sv | 152 +++++++++++++++
 tb/tb_mem_io_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Controller-facing RAM/I-O port plus the UART-style TX sink and sticky status flags.
// master = controller/sink side, slave = responder side.
interface mem_io_responder_if;
  logic        readyIn;
  logic        ramSelect;
  logic [31:0] ramAddr;
  logic [7:0]  ramIn;
  logic [7:0]  ramOut;
  logic        ioBufferFull;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady;
  logic        simHalt;
  logic        txOverflow;

  modport master (
    output readyIn, ramSelect, ramAddr, ramIn, txReady,
    input  ramOut, ioBufferFull, txValid, txData, simHalt, txOverflow
  );

  modport slave (
    input  readyIn, ramSelect, ramAddr, ramIn, txReady,
    output ramOut, ioBufferFull, txValid, txData, simHalt, txOverflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM + MMIO responder with console TX FIFO; reads return 1 cycle after the address.
// No port stalls: ioBufferFull throttles I/O writes, a full FIFO drops pushes, txReady stalls the drain.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int TX_MARGIN  = 2,
  parameter int TX_GAP     = 3
) (
  input logic               clockIn,
  input logic               resetIn,
  mem_io_responder_if.slave bus
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] HIGH_LVL = CNT_W'(TX_DEPTH - TX_MARGIN);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP);

  typedef enum logic [1:0] {IDLE, SEND, GAP} txState_t;

  // Address decode
  logic                  isIo;
  logic [3:0]            ioOffset;
  logic [ADDR_WIDTH-1:0] ramIndex;
  logic                  ramRead, ramWrite, ioRead, ioWrite;
  logic                  pushReq, haltReq;
  logic                  unusedAddr;

  assign isIo       = (bus.ramAddr[17:16] == 2'b11);
  assign ioOffset   = bus.ramAddr[3:0];
  assign ramIndex   = bus.ramAddr[ADDR_WIDTH-1:0];
  assign ramRead    = bus.readyIn && !isIo && !bus.ramSelect;
  assign ramWrite   = bus.readyIn && !isIo &&  bus.ramSelect;
  assign ioRead     = bus.readyIn &&  isIo && !bus.ramSelect;
  assign ioWrite    = bus.readyIn &&  isIo &&  bus.ramSelect;
  assign pushReq    = ioWrite && (ioOffset == 4'h0);
  assign haltReq    = ioWrite && (ioOffset == 4'h8);
  assign unusedAddr = ^bus.ramAddr[31:18];

  // Storage
  logic [7:0]       mem     [2**ADDR_WIDTH];
  logic [7:0]       fifoMem [TX_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count, nextCount;
  logic             pushDo, popDo;

  // Drain FSM and registered outputs
  txState_t         state, nextState;
  logic [GAP_W-1:0] gapCnt, nextGap;
  logic             txValidC;
  logic [7:0]       txDataC;
  logic [7:0]       ramOutQ;
  logic             ioFullQ, simHaltQ, txOverflowQ;

  // A full FIFO still takes a push when the drain pops on the same edge.
  assign pushDo    = pushReq && ((count != FULL_LVL) || popDo);
  assign nextCount = count + CNT_W'(pushDo) - CNT_W'(popDo);
  assign txDataC   = (state == SEND) ? fifoMem[rdPtr] : 8'h00;

  always_ff @(posedge clockIn) begin
    if (ramWrite) mem[ramIndex] <= bus.ramIn;
  end

  always_ff @(posedge clockIn) begin
    if (pushDo) fifoMem[wrPtr] <= bus.ramIn;
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      ramOutQ <= 8'h00;
    end else if (bus.readyIn) begin
      if (ramRead)
        ramOutQ <= mem[ramIndex];
      else if (ioRead && (ioOffset == 4'h4))
        ramOutQ <= {6'b0, txValidC, ioFullQ};
      else
        ramOutQ <= 8'h00;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      ioFullQ     <= 1'b0;
      simHaltQ    <= 1'b0;
      txOverflowQ <= 1'b0;
    end else begin
      if (pushDo) wrPtr <= wrPtr + PTR_W'(1);
      if (popDo)  rdPtr <= rdPtr + PTR_W'(1);
      count   <= nextCount;
      ioFullQ <= (nextCount >= HIGH_LVL);
      if (haltReq) simHaltQ <= 1'b1;
      if (pushReq && !pushDo) txOverflowQ <= 1'b1;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state  <= IDLE;
      gapCnt <= '0;
    end else begin
      state  <= nextState;
      gapCnt <= nextGap;
    end
  end

  always_comb begin
    nextState = state;
    nextGap   = gapCnt;
    popDo     = 1'b0;
    txValidC  = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && (gapCnt == '0)) nextState = SEND;
      end
      SEND: begin
        txValidC = 1'b1;
        if (bus.txReady) begin
          popDo = 1'b1;
          if (TX_GAP == 0) begin
            // A same-cycle push is always accepted while popping.
            nextState = ((count > CNT_W'(1)) || pushReq) ? SEND : IDLE;
          end else begin
            nextState = GAP;
            nextGap   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gapCnt > GAP_W'(1)) begin
          nextGap = gapCnt - GAP_W'(1);
        end else begin
          nextGap   = '0;
          nextState = (count != '0) ? SEND : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.ramOut       = ramOutQ;
  assign bus.ioBufferFull = ioFullQ;
  assign bus.txValid      = txValidC;
  assign bus.txData       = txDataC;
  assign bus.simHalt      = simHaltQ;
  assign bus.txOverflow   = txOverflowQ;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: read-data and TX-byte scoreboards checked with immediate assertions.
module tb_mem_io_responder;
  localparam int HIGH_LVL = 6;

  logic clockIn;
  logic resetIn;
  mem_io_responder_if bus();

  mem_io_responder #(
    .ADDR_WIDTH(17), .TX_DEPTH(8), .TX_MARGIN(2), .TX_GAP(3)
  ) dut (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .bus    (bus)
  );

  int         nTests = 0;
  int         nFail  = 0;
  int         cyc    = 0;
  logic [7:0] readQ[$];
  logic [7:0] txQ[$];
  int         acceptQ[$];

  initial begin
    clockIn = 1'b0;
    forever #5 clockIn = ~clockIn;
  end

  always @(posedge clockIn) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic checkN(input string tag, input int got, input int exp);
    nTests++;
    assert (got == exp) else begin
      nFail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic idle();
    bus.readyIn   = 1'b0;
    bus.ramSelect = 1'b0;
    bus.ramAddr   = 32'h0;
    bus.ramIn     = 8'h00;
  endtask

  task automatic ramWr(input logic [31:0] addr, input logic [7:0] data);
    bus.readyIn   = 1'b1;
    bus.ramSelect = 1'b1;
    bus.ramAddr   = addr;
    bus.ramIn     = data;
    tick();
    idle();
  endtask

  task automatic ramRd(input string tag, input logic [31:0] addr, input logic [7:0] exp);
    readQ.push_back(exp);
    bus.readyIn   = 1'b1;
    bus.ramSelect = 1'b0;
    bus.ramAddr   = addr;
    tick();
    idle();
    check8(tag, bus.ramOut, readQ.pop_front());
  endtask

  // Every presented TX byte must be the oldest byte the bench has queued.
  always @(negedge clockIn) begin
    if (resetIn === 1'b1 && bus.txValid === 1'b1) begin
      check1("txQueued", txQ.size() != 0, 1'b1);
      if (txQ.size() != 0) begin
        check8("txData", bus.txData, txQ[0]);
        if (bus.txReady === 1'b1) begin
          void'(txQ.pop_front());
          acceptQ.push_back(cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    resetIn     = 1'b0;
    bus.txReady = 1'b0;
    idle();
    repeat (3) tick();
    check8("rstRamOut", bus.ramOut, 8'h00);
    check1("rstTxValid", bus.txValid, 1'b0);
    check8("rstTxData", bus.txData, 8'h00);
    check1("rstFull", bus.ioBufferFull, 1'b0);
    check1("rstHalt", bus.simHalt, 1'b0);
    check1("rstOvf", bus.txOverflow, 1'b0);
    resetIn = 1'b1;
    tick();

    // RAM read/write, aliasing preload, readyIn gating
    ramWr(32'h0002_0011, 8'h3C);
    ramWr(32'h0000_0010, 8'hA5);
    ramRd("ramA5", 32'h0000_0010, 8'hA5);
    ramRd("ramPreload", 32'h0000_0011, 8'h3C);
    bus.readyIn   = 1'b0;
    bus.ramSelect = 1'b1;
    bus.ramAddr   = 32'h0000_0010;
    bus.ramIn     = 8'hFF;
    tick();
    check8("holdOut", bus.ramOut, 8'h3C);
    idle();
    ramRd("noWrite", 32'h0000_0010, 8'hA5);
    ramWr(32'h0000_0012, 8'h77);
    check8("wrClears", bus.ramOut, 8'h00);
    ramRd("ram77", 32'h0000_0012, 8'h77);

    // Drain with rate limiting
    bus.txReady = 1'b1;
    acceptQ.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'(32'h11 * (i + 1));
      txQ.push_back(b);
      ramWr(32'h0003_0000, b);
    end
    for (int i = 0; i < 200 && txQ.size() != 0; i++) tick();
    checkN("drain4Done", txQ.size(), 0);
    checkN("drain4Count", acceptQ.size(), 4);
    for (int i = 1; i < acceptQ.size(); i++)
      checkN("txSpacing", acceptQ[i] - acceptQ[i-1], 4);
    repeat (5) tick();

    // Fill with sink stalled
    bus.txReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = 8'(32'h50 + i);
      txQ.push_back(b);
      ramWr(32'h0003_0000, b);
      if (i == 4) check1("fullLow5", bus.ioBufferFull, 1'b0);
    end
    check1("fullHigh6", bus.ioBufferFull, 1'b1);
    check1("noOvf6", bus.txOverflow, 1'b0);
    ramRd("status03", 32'h0003_0004, 8'h03);
    txQ.push_back(8'h56);
    ramWr(32'h0003_0000, 8'h56);
    txQ.push_back(8'h57);
    ramWr(32'h0003_0000, 8'h57);
    check1("fullAt8", bus.ioBufferFull, 1'b1);
    check1("noOvf8", bus.txOverflow, 1'b0);

    // Full FIFO: push on the same edge as a pop is accepted
    txQ.push_back(8'h99);
    bus.txReady   = 1'b1;
    bus.readyIn   = 1'b1;
    bus.ramSelect = 1'b1;
    bus.ramAddr   = 32'h0003_0000;
    bus.ramIn     = 8'h99;
    tick();
    bus.txReady = 1'b0;
    idle();
    check1("pushPopOvf", bus.txOverflow, 1'b0);
    check1("pushPopFull", bus.ioBufferFull, 1'b1);
    ramRd("statusGap", 32'h0003_0004, 8'h01);

    // Push into a full FIFO with no pop is dropped
    ramWr(32'h0003_0000, 8'hEE);
    check1("ovfSet", bus.txOverflow, 1'b1);

    bus.txReady = 1'b1;
    for (int i = 0; i < 200 && txQ.size() != 0; i++) begin
      tick();
      check1("fullTrack", bus.ioBufferFull, txQ.size() >= HIGH_LVL);
    end
    checkN("drain8Done", txQ.size(), 0);
    repeat (6) tick();
    check1("idleAfter", bus.txValid, 1'b0);
    check1("fullClear", bus.ioBufferFull, 1'b0);
    check1("ovfSticky", bus.txOverflow, 1'b1);

    // I/O reads, unmapped offsets, HALT
    ramRd("txdataRd", 32'h0003_0000, 8'h00);
    ramRd("unmappedRd", 32'h0003_000C, 8'h00);
    ramWr(32'h0003_000C, 8'h5A);
    repeat (3) tick();
    check1("haltNotYet", bus.simHalt, 1'b0);
    ramWr(32'h0003_0008, 8'h01);
    check1("haltSet", bus.simHalt, 1'b1);
    ramWr(32'h0000_0020, 8'h00);
    repeat (4) tick();
    check1("haltSticky", bus.simHalt, 1'b1);

    // Reset in the middle of a drain
    bus.txReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b = 8'(32'hC0 + i);
      txQ.push_back(b);
      ramWr(32'h0003_0000, b);
    end
    bus.txReady = 1'b1;
    tick();
    bus.txReady = 1'b0;
    repeat (4) tick();
    check1("preRstValid", bus.txValid, 1'b1);
    check1("preRstFull", bus.ioBufferFull, 1'b1);
    resetIn = 1'b0;
    txQ.delete();
    #2;
    check1("asyncTxValid", bus.txValid, 1'b0);
    check1("asyncFull", bus.ioBufferFull, 1'b0);
    check1("asyncHalt", bus.simHalt, 1'b0);
    check1("asyncOvf", bus.txOverflow, 1'b0);
    tick();
    resetIn = 1'b1;
    repeat (3) tick();
    check1("postRstValid", bus.txValid, 1'b0);
    ramRd("statusRst", 32'h0003_0004, 8'h00);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
